// File: rtl/riscv_fetch_unit_if.sv
// Bundles the instruction-memory request/response port and the decode-side
// valid/ready port of the fetch unit. master = fetch unit, slave = environment.
interface riscv_fetch_unit_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
  logic            if_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// capture into a small {pc, instr} prefetch FIFO, and redirect flush.
module riscv_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  riscv_fetch_unit_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [ILEN-1:0] instr_mem [DEPTH];

  logic [CW:0] credit_used;
  logic        req;
  logic        grant;
  logic        resp;
  logic        push;
  logic        pop;

  assign credit_used = {1'b0, out_q} + {1'b0, cnt_q};
  assign req   = !rst && !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign grant = req && bus.imem_gnt;
  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp  = bus.imem_rvalid && (out_q != '0);
  assign push  = resp && (drop_q == '0) && !bus.redirect_valid;
  assign pop   = (cnt_q != '0) && bus.if_ready && !bus.redirect_valid;

  always_comb begin
    out_d      = out_q + CW'(grant) - CW'(resp);
    fetch_pc_d = grant ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    drop_d     = (resp && (drop_q != '0)) ? drop_q - CW'(1) : drop_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    // resp_pc tracks the PC of the next response that will actually be kept.
    resp_pc_d  = push ? resp_pc_q + XLEN'(4) : resp_pc_q;
    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old stream.
      drop_d     = out_d;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      resp_pc_d  = {bus.redirect_pc[XLEN-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr_q]    <= resp_pc_q;
      instr_mem[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.if_valid  = (cnt_q != '0);
  // Storage is not reset, so outputs are forced to zero while empty.
  assign bus.if_pc     = (cnt_q != '0) ? pc_mem[rd_ptr_q]    : '0;
  assign bus.if_instr  = (cnt_q != '0) ? instr_mem[rd_ptr_q] : '0;
endmodule
